// File: rtl/digital_filter_pkg.sv
// Shared types, default widths and saturation limits for the sample-stream filters
// (difference filter, integrator).
package digital_filter_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    // Largest / smallest value representable in a w-bit two's complement word.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational saturator: narrows a W+1 bit signed value to W bits, clamping
// to the W-bit range and flagging when the clamp was active.
module sat_clamp
    import digital_filter_pkg::*;
#(
    parameter int W = DEF_ACC_W
) (
    input  logic signed [W:0]   din,
    output logic signed [W-1:0] dout,
    output logic                sat
);

    localparam logic signed [63:0] MAX64   = sat_max(W);
    localparam logic signed [63:0] MIN64   = sat_min(W);
    localparam logic signed [W:0]  MAX_EXT = $signed(MAX64[W:0]);
    localparam logic signed [W:0]  MIN_EXT = $signed(MIN64[W:0]);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        dout = din[W-1:0];
        sat  = 1'b0;
        if (din > MAX_EXT) begin
            dout = MAX_EXT[W-1:0];
            sat  = 1'b1;
        end else if (din < MIN_EXT) begin
            dout = MIN_EXT[W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/digital_integrator.sv
// Leaky saturating integrator on a valid/ready stream:
// y[n] = y[n-1] - (y[n-1] >>> LEAK_SHIFT) + x[n], one cycle latency.
module digital_integrator
    import digital_filter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int LEAK_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     sat_flag
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   x_ext;
    logic signed [ACC_W:0]   leak;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] sum_clamped;
    logic                    sum_sat;
    logic                    accept;
    logic                    consume;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // The accumulator is the output register: out_data always shows y[n].
    assign out_data = acc;

    always_comb begin
        acc_ext = {acc[ACC_W-1], acc};
        x_ext   = {{(ACC_W + 1 - DATA_W){in_data[DATA_W-1]}}, in_data};
        leak    = '0;
        if (LEAK_SHIFT > 0) begin
            leak = acc_ext >>> LEAK_SHIFT;
        end
        sum = acc_ext - leak + x_ext;
    end

    sat_clamp #(.W(ACC_W)) u_clamp (
        .din  (sum),
        .dout (sum_clamped),
        .sat  (sum_sat)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clr) begin
            sat_flag <= 1'b0;
            if (accept) begin
                acc       <= x_ext[ACC_W-1:0];
                out_valid <= 1'b1;
            end else begin
                acc       <= '0;
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            acc       <= sum_clamped;
            out_valid <= 1'b1;
            if (sum_sat) begin
                sat_flag <= 1'b1;
            end
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule
